// File: rtl/hid_report_capture.sv
// Multi-channel HID report capture: per-channel history ring, fill level and
// saturating accept counter, with a registered readout of one selected entry.
module hid_report_capture #(
    parameter int C_channels    = 3,
    parameter int C_report_bits = 64,
    parameter int C_depth       = 4,
    parameter int C_change_only = 0,
    parameter int C_count_bits  = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [C_channels*C_report_bits-1:0]               report_i,
    input  logic [C_channels-1:0]                             valid_i,
    input  logic                                              freeze_i,
    input  logic                                              clear_i,
    input  logic [((C_channels > 1) ? $clog2(C_channels) : 1)-1:0] sel_ch_i,
    input  logic [$clog2(C_depth)-1:0]                        sel_hist_i,
    output logic [C_report_bits-1:0]                          data_o,
    output logic [C_count_bits-1:0]                           count_o,
    output logic [$clog2(C_depth):0]                          fill_o,
    output logic                                              new_o
);

    localparam int CH_W = (C_channels > 1) ? $clog2(C_channels) : 1;
    localparam int HW   = $clog2(C_depth);
    localparam int FW   = HW + 1;

    logic [C_report_bits-1:0] hist    [C_channels][C_depth];
    logic [C_report_bits-1:0] hist_nx [C_channels][C_depth];
    logic [FW-1:0]            fill    [C_channels];
    logic [FW-1:0]            fill_nx [C_channels];
    logic [C_count_bits-1:0]  count   [C_channels];
    logic [C_count_bits-1:0]  count_nx[C_channels];
    logic [C_channels-1:0]    accept;

    logic [C_report_bits-1:0] data_nx;
    logic [C_count_bits-1:0]  count_sel;
    logic [FW-1:0]            fill_sel;
    logic                     new_nx;

    always_comb begin
        for (int unsigned c = 0; c < C_channels; c++) begin
            accept[c] = valid_i[c] && !freeze_i && !clear_i;
            // Duplicate test is against the stored newest entry, never a stale one.
            if (C_change_only != 0 && fill[c] != '0 &&
                report_i[c*C_report_bits +: C_report_bits] == hist[c][0])
                accept[c] = 1'b0;

            hist_nx[c]  = hist[c];
            fill_nx[c]  = fill[c];
            count_nx[c] = count[c];

            if (clear_i) begin
                fill_nx[c]  = '0;
                count_nx[c] = '0;
            end else if (accept[c]) begin
                hist_nx[c][0] = report_i[c*C_report_bits +: C_report_bits];
                for (int unsigned d = 1; d < C_depth; d++)
                    hist_nx[c][d] = hist[c][d-1];
                if (fill[c] != FW'(C_depth))
                    fill_nx[c] = fill[c] + 1'b1;
                if (count[c] != '1)
                    count_nx[c] = count[c] + 1'b1;
            end
        end
    end

    // Readout uses next-state values so an accept is visible with its new_o pulse.
    always_comb begin
        data_nx   = '0;
        count_sel = '0;
        fill_sel  = '0;
        new_nx    = 1'b0;
        for (int unsigned c = 0; c < C_channels; c++) begin
            if (CH_W'(c) == sel_ch_i) begin
                fill_sel  = fill_nx[c];
                count_sel = count_nx[c];
                new_nx    = accept[c];
                for (int unsigned d = 0; d < C_depth; d++) begin
                    if (HW'(d) == sel_hist_i && FW'(d) < fill_nx[c])
                        data_nx = hist_nx[c][d];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        hist <= hist_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < C_channels; c++) begin
                fill[c]  <= '0;
                count[c] <= '0;
            end
            data_o  <= '0;
            count_o <= '0;
            fill_o  <= '0;
            new_o   <= 1'b0;
        end else begin
            fill    <= fill_nx;
            count   <= count_nx;
            data_o  <= data_nx;
            count_o <= count_sel;
            fill_o  <= fill_sel;
            new_o   <= new_nx;
        end
    end

endmodule

// File: tb/tb_hid_report_capture.sv
// Directed bench: three capture instances (default, drop-duplicates, 4-bit
// counters) share one stimulus stream; expected values are hand-computed.
module tb_hid_report_capture;

    logic          clk = 1'b0;
    logic          reset;
    logic [191:0]  report;
    logic [2:0]    valid;
    logic          freeze;
    logic          clear;
    logic [1:0]    sel_ch;
    logic [1:0]    sel_hist;

    logic [63:0]   data_a, data_b, data_c;
    logic [15:0]   count_a, count_b;
    logic [3:0]    count_c;
    logic [2:0]    fill_a, fill_b, fill_c;
    logic          new_a, new_b, new_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hid_report_capture #(.C_channels(3), .C_report_bits(64), .C_depth(4),
                         .C_change_only(0), .C_count_bits(16)) u_a (
        .clk(clk), .reset(reset), .report_i(report), .valid_i(valid),
        .freeze_i(freeze), .clear_i(clear), .sel_ch_i(sel_ch), .sel_hist_i(sel_hist),
        .data_o(data_a), .count_o(count_a), .fill_o(fill_a), .new_o(new_a));

    hid_report_capture #(.C_channels(3), .C_report_bits(64), .C_depth(4),
                         .C_change_only(1), .C_count_bits(16)) u_b (
        .clk(clk), .reset(reset), .report_i(report), .valid_i(valid),
        .freeze_i(freeze), .clear_i(clear), .sel_ch_i(sel_ch), .sel_hist_i(sel_hist),
        .data_o(data_b), .count_o(count_b), .fill_o(fill_b), .new_o(new_b));

    hid_report_capture #(.C_channels(3), .C_report_bits(64), .C_depth(4),
                         .C_change_only(0), .C_count_bits(4)) u_c (
        .clk(clk), .reset(reset), .report_i(report), .valid_i(valid),
        .freeze_i(freeze), .clear_i(clear), .sel_ch_i(sel_ch), .sel_hist_i(sel_hist),
        .data_o(data_c), .count_o(count_c), .fill_o(fill_c), .new_o(new_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rep(input int ch, input logic [63:0] val);
        report[ch*64 +: 64] = val;
    endtask

    initial begin
        reset = 1'b1; report = '0; valid = '0; freeze = 1'b0; clear = 1'b0;
        sel_ch = 2'd0; sel_hist = 2'd0;
        step(); step();
        reset = 1'b0;
        check("rst_data", data_a, 64'd0);
        check("rst_fill", 64'(fill_a), 64'd0);
        check("rst_count", 64'(count_a), 64'd0);
        check("rst_new", 64'(new_a), 64'd0);

        // Back-to-back accepts on channel 0
        set_rep(0, 64'h1111_1111_1111_1111); valid = 3'b001;
        step();
        check("b2b_new1", 64'(new_a), 64'd1);
        check("b2b_fill1", 64'(fill_a), 64'd1);
        set_rep(0, 64'h2222_2222_2222_2222);
        step();
        check("b2b_new2", 64'(new_a), 64'd1);
        check("b2b_fill2", 64'(fill_a), 64'd2);
        check("b2b_count2", 64'(count_a), 64'd2);
        check("b2b_hist0", data_a, 64'h2222_2222_2222_2222);
        valid = '0;
        step();
        check("b2b_new_off", 64'(new_a), 64'd0);
        sel_hist = 2'd1; step();
        check("b2b_hist1", data_a, 64'h1111_1111_1111_1111);
        sel_hist = 2'd2; step();
        check("b2b_hist2_empty", data_a, 64'd0);

        // Overflow on channel 1: A..F, depth 4 keeps F,E,D,C
        sel_ch = 2'd1; sel_hist = 2'd0;
        step();
        check("selch_no_new", 64'(new_a), 64'd0);
        check("ch1_empty_fill", 64'(fill_a), 64'd0);
        valid = 3'b010;
        for (int i = 0; i < 6; i++) begin
            set_rep(1, {16{4'(10 + i)}});
            step();
        end
        valid = '0;
        step();
        check("ovf_fill", 64'(fill_a), 64'd4);
        check("ovf_count", 64'(count_a), 64'd6);
        for (int h = 0; h < 4; h++) begin
            sel_hist = 2'(h); step();
            check($sformatf("ovf_hist%0d", h), data_a, {16{4'(15 - h)}});
        end

        // Duplicates on channel 2: X, X, Y
        sel_ch = 2'd2; sel_hist = 2'd0;
        valid = 3'b100;
        set_rep(2, 64'hDEAD_BEEF_0000_0001); step();
        check("dup_new_a0", 64'(new_a), 64'd1);
        check("dup_new_b0", 64'(new_b), 64'd1);
        step();
        check("dup_new_a1", 64'(new_a), 64'd1);
        check("dup_new_b1", 64'(new_b), 64'd0);
        set_rep(2, 64'hDEAD_BEEF_0000_0002); step();
        check("dup_new_a2", 64'(new_a), 64'd1);
        check("dup_new_b2", 64'(new_b), 64'd1);
        valid = '0; step();
        check("dup_count_b", 64'(count_b), 64'd2);
        check("dup_fill_b", 64'(fill_b), 64'd2);
        check("dup_count_a", 64'(count_a), 64'd3);
        check("dup_fill_a", 64'(fill_a), 64'd3);
        check("dup_hist0_b", data_b, 64'hDEAD_BEEF_0000_0002);
        sel_hist = 2'd1; step();
        check("dup_hist1_b", data_b, 64'hDEAD_BEEF_0000_0001);
        check("dup_hist1_a", data_a, 64'hDEAD_BEEF_0000_0001);

        // Clear beats simultaneous valid; then a clean accept on all channels
        sel_hist = 2'd0;
        set_rep(0, 64'h0A); set_rep(1, 64'h0B); set_rep(2, 64'h0C);
        valid = 3'b111; clear = 1'b1;
        step();
        check("clr_new", 64'(new_a), 64'd0);
        clear = 1'b0; valid = '0;
        for (int c = 0; c < 3; c++) begin
            sel_ch = 2'(c); step();
            check($sformatf("clr_fill%0d", c), 64'(fill_a), 64'd0);
            check($sformatf("clr_count%0d", c), 64'(count_a), 64'd0);
            check($sformatf("clr_data%0d", c), data_a, 64'd0);
        end
        valid = 3'b111; step(); valid = '0;
        for (int c = 0; c < 3; c++) begin
            sel_ch = 2'(c); step();
            check($sformatf("post_fill%0d", c), 64'(fill_a), 64'd1);
            check($sformatf("post_count%0d", c), 64'(count_a), 64'd1);
            check($sformatf("post_data%0d", c), data_a, 64'h0A + 64'(c));
        end
        sel_ch = 2'd3; step();
        check("oor_fill", 64'(fill_a), 64'd0);
        check("oor_count", 64'(count_a), 64'd0);
        check("oor_data", data_a, 64'd0);

        // Freeze holds everything
        sel_ch = 2'd0; freeze = 1'b1; valid = 3'b111;
        set_rep(0, 64'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_new", 64'(new_a), 64'd0);
            check("frz_fill", 64'(fill_a), 64'd1);
            check("frz_count", 64'(count_a), 64'd1);
        end
        check("frz_data", data_a, 64'h0A);
        freeze = 1'b0; valid = '0;

        // Counter saturation with 4-bit counters
        clear = 1'b1; step(); clear = 1'b0;
        valid = 3'b001;
        for (int i = 0; i < 20; i++) begin
            set_rep(0, 64'h100 + 64'(i));
            step();
            check("sat_new", 64'(new_c), 64'd1);
        end
        valid = '0; step();
        check("sat_count_c", 64'(count_c), 64'd15);
        check("sat_fill_c", 64'(fill_c), 64'd4);
        check("sat_count_a", 64'(count_a), 64'd20);
        check("sat_count_b", 64'(count_b), 64'd20);
        check("sat_hist0_c", data_c, 64'h113);

        // Reset mid-stream
        valid = 3'b001; set_rep(0, 64'h999);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; valid = '0;
        check("mrst_data", data_a, 64'd0);
        check("mrst_fill", 64'(fill_a), 64'd0);
        check("mrst_count", 64'(count_a), 64'd0);
        check("mrst_new", 64'(new_a), 64'd0);
        check("mrst_count_c", 64'(count_c), 64'd0);
        step();
        check("mrst_hold_fill", 64'(fill_a), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
